// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte per request using the
// request-to-send sequence on open-drain clock/data pads and reports ack or failure.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_DATA,
    S_PARITY,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_ERR
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t           state;
  logic [8:0]       shift_reg;
  logic [3:0]       bit_cnt;
  logic [CNT_W-1:0] cnt;

  logic clk_sync_p0, clk_sync_p1, clk_prev_p2, fall_p2;
  logic data_sync_p0, data_sync_p1;
  logic in_frame, timeout_hit;

  // Pad synchronizers (p0, p1) and registered falling-edge detect (p2)
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync_p0  <= 1'b1;
      clk_sync_p1  <= 1'b1;
      clk_prev_p2  <= 1'b1;
      fall_p2      <= 1'b0;
      data_sync_p0 <= 1'b1;
      data_sync_p1 <= 1'b1;
    end else begin
      clk_sync_p0  <= ps2_clock_in;
      clk_sync_p1  <= clk_sync_p0;
      clk_prev_p2  <= clk_sync_p1;
      fall_p2      <= clk_prev_p2 & ~clk_sync_p1;
      data_sync_p0 <= ps2_data_in;
      data_sync_p1 <= data_sync_p0;
    end
  end

  assign in_frame = (state == S_REQ) || (state == S_DATA) || (state == S_PARITY) ||
                    (state == S_ACK) || (state == S_WAIT_IDLE);
  assign timeout_hit = (cnt == TIMEOUT_LAST);

  // Protocol FSM; every pad enable and status output is a flop
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      cnt          <= '0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      tx_error     <= 1'b0;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (in_frame) cnt <= cnt + 1'b1;

      if (in_frame && timeout_hit) begin
        ps2_clock_oe <= 1'b0;
        ps2_data_oe  <= 1'b0;
        tx_error     <= 1'b1;
        state        <= S_ERR;
      end else begin
        case (state)
          S_IDLE: begin
            if (tx_start) begin
              shift_reg    <= {odd_parity(tx_data), tx_data};
              bit_cnt      <= '0;
              cnt          <= '0;
              tx_busy      <= 1'b1;
              ps2_clock_oe <= 1'b1;
              state        <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (cnt == INHIBIT_LAST) begin
              ps2_clock_oe <= 1'b0;
              ps2_data_oe  <= 1'b1;
              cnt          <= '0;
              state        <= S_REQ;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_REQ: begin
            if (fall_p2) begin
              ps2_data_oe <= ~shift_reg[0];
              bit_cnt     <= '0;
              state       <= S_DATA;
            end
          end
          S_DATA: begin
            // shift_reg[1] is the bit after the one on the wire; after d7 it is parity
            if (fall_p2) begin
              ps2_data_oe <= ~shift_reg[1];
              shift_reg   <= shift_reg >> 1;
              if (bit_cnt == 4'd7) state <= S_PARITY;
              else bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_PARITY: begin
            if (fall_p2) begin
              ps2_data_oe <= 1'b0;
              state       <= S_ACK;
            end
          end
          S_ACK: begin
            if (fall_p2) begin
              if (!data_sync_p1) begin
                state <= S_WAIT_IDLE;
              end else begin
                ps2_clock_oe <= 1'b0;
                ps2_data_oe  <= 1'b0;
                tx_error     <= 1'b1;
                state        <= S_ERR;
              end
            end
          end
          S_WAIT_IDLE: begin
            if (clk_sync_p1 && data_sync_p1) begin
              tx_done <= 1'b1;
              state   <= S_DONE;
            end
          end
          S_DONE, S_ERR: begin
            tx_busy <= 1'b0;
            state   <= S_IDLE;
          end
          default: begin
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            tx_busy      <= 1'b0;
            state        <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model, PS/2 device model and a scoreboard
// that checks each frame's data-line sequence and outcome pulse.
module tb_ps2_host_tx;

  localparam int INHIBIT = 5000;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 40;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clock_in, ps2_data_in, ps2_clock_oe, ps2_data_oe;

  logic        dev_clk_low = 1'b0;
  logic        dev_data_low = 1'b0;
  logic        dev_en = 1'b1;
  logic        dev_ack = 1'b1;
  logic [10:0] frame_cap = '0;
  logic        chk_busy_drop = 1'b0;

  int checks = 0;
  int errors = 0;

  // frame bit order: [0]=start, [8:1]=d7..d0 reversed into d0 at [1], [9]=parity, [10]=stop
  typedef struct {
    logic [10:0] frame;
    logic        ok;
    logic        chk_frame;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [10:0] FR_ED = 11'b0_0_00010010_1;
  localparam logic [10:0] FR_00 = 11'b0_0_11111111_1;
  localparam logic [10:0] FR_FF = 11'b0_0_00000000_1;
  localparam logic [10:0] FR_01 = 11'b0_1_11111110_1;
  localparam logic [10:0] FR_F4 = 11'b0_1_00001011_1;

  assign ps2_clock_in = ~(ps2_clock_oe | dev_clk_low);
  assign ps2_data_in  = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock(clock), .resetn(resetn), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
    .ps2_clock_in(ps2_clock_in), .ps2_data_in(ps2_data_in),
    .ps2_clock_oe(ps2_clock_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [10:0] fr, input logic ok, input logic chk_frame);
    exp_t e;
    e.frame = fr;
    e.ok = ok;
    e.chk_frame = chk_frame;
    exp_q.push_back(e);
  endtask

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    chk("accept_busy", 32'(tx_busy), 32'd1);
    chk("accept_clock_oe", 32'(ps2_clock_oe), 32'd1);
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (tx_busy && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_idle"}, 32'(tx_busy), 32'd0);
  endtask

  // Device: answers a request-to-send with 11 clock pulses, reads data on each rise
  initial begin
    forever begin
      @(negedge clock);
      if (!ps2_clock_in) begin
        while (!ps2_clock_in) @(negedge clock);
        if (dev_en && !ps2_data_in) begin
          frame_cap = '0;
          frame_cap[0] = ps2_data_oe;
          repeat (HALF / 2) @(negedge clock);
          for (int b = 1; b <= 10; b++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clock);
            dev_clk_low = 1'b0;
            frame_cap[b] = ps2_data_oe;
            repeat (HALF) @(negedge clock);
          end
          dev_data_low = dev_ack;
          repeat (5) @(negedge clock);
          dev_clk_low = 1'b1;
          repeat (HALF) @(negedge clock);
          dev_clk_low = 1'b0;
          repeat (HALF) @(negedge clock);
          dev_data_low = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (chk_busy_drop) begin
        chk("busy_drop", 32'(tx_busy), 32'd0);
        chk_busy_drop = 1'b0;
      end
      if (resetn && (tx_done || tx_error)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'({tx_done, tx_error}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("outcome_done", 32'(tx_done), 32'(e.ok));
          chk("outcome_error", 32'(tx_error), 32'(!e.ok));
          if (e.chk_frame) chk("frame_oe", 32'(frame_cap), 32'(e.frame));
          chk("pads_released", 32'({ps2_clock_oe, ps2_data_oe}), 32'd0);
          chk_busy_drop = 1'b1;
        end
      end
    end
  end

  initial begin
    int n;
    int hi;
    int act;

    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_error", 32'(tx_error), 32'd0);
    chk("rst_clock_oe", 32'(ps2_clock_oe), 32'd0);
    chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clock);

    // 0xED, data changed after acceptance, extra starts while busy
    push(FR_ED, 1'b1, 1'b1);
    start_tx(8'hED);
    tx_data = 8'h00;
    repeat (100) @(negedge clock);
    tx_data = 8'h55;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    repeat (5300) @(negedge clock);
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    wait_idle("ed", n);
    act = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (ps2_clock_oe || tx_busy) act++;
    end
    chk("no_second_frame", 32'(act), 32'd0);

    push(FR_00, 1'b1, 1'b1);
    start_tx(8'h00);
    wait_idle("x00", n);

    push(FR_FF, 1'b1, 1'b1);
    start_tx(8'hFF);
    wait_idle("xff", n);

    // 0x01 with the ack withheld
    dev_ack = 1'b0;
    push(FR_01, 1'b0, 1'b1);
    start_tx(8'h01);
    wait_idle("nack", n);
    dev_ack = 1'b1;
    repeat (200) @(negedge clock);

    // Device never clocks
    dev_en = 1'b0;
    push('0, 1'b0, 1'b0);
    start_tx(8'hA5);
    hi = 1;
    for (int i = 0; i < INHIBIT + 1000; i++) begin
      @(negedge clock);
      if (!ps2_clock_oe) break;
      hi++;
    end
    chk("inhibit_len", 32'(hi), 32'(INHIBIT));
    chk("req_data_oe", 32'(ps2_data_oe), 32'd1);
    wait_idle("timeout", n);
    chk("timeout_window", 32'(n >= TIMEOUT - 1 && n <= TIMEOUT + 4), 32'd1);
    dev_en = 1'b1;
    repeat (20) @(negedge clock);

    // Reset during DATA
    start_tx(8'h3C);
    n = 0;
    while (ps2_clock_oe && n < INHIBIT + 1000) begin
      @(negedge clock);
      n++;
    end
    chk("rst_test_req", 32'(ps2_clock_oe), 32'd0);
    repeat (150) @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("midrst_pads", 32'({ps2_clock_oe, ps2_data_oe}), 32'd0);
    chk("midrst_busy", 32'(tx_busy), 32'd0);
    chk("midrst_pulses", 32'({tx_done, tx_error}), 32'd0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (1200) @(negedge clock);
    chk("postrst_busy", 32'(tx_busy), 32'd0);
    chk("postrst_clock_oe", 32'(ps2_clock_oe), 32'd0);

    // Back-to-back: 0xF4 requested in the cycle after 0xED completes
    push(FR_ED, 1'b1, 1'b1);
    start_tx(8'hED);
    n = 0;
    while (!tx_done && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk("b2b_done_seen", 32'(tx_done), 32'd1);
    @(negedge clock);
    push(FR_F4, 1'b1, 1'b1);
    start_tx(8'hF4);
    wait_idle("f4", n);
    repeat (10) @(negedge clock);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
